// File: rtl/audio_mixer_out.sv
// ---------------------------------------------------------------------------
// audio_mixer_out
//
// HDMI audio back end. A Bresenham divider derives the audio sample clock
// from the pixel clock at an exact long-run rate. Once per sample the block
// mixes NUM_CH stereo sources, each with its own volume gain, applies the
// global mute, saturates, and presents a stable stereo word to the HDMI
// encoder.
//
// Optional feature (macro AUDIO_VOL_RAMP_EN):
//   defined   - each gain moves by one step per sample toward its target,
//               so reset, mute and volume changes do not pop.
//   undefined - each gain jumps straight to its target at every sample.
//
// Ports:
//   clk          pixel clock
//   reset        asynchronous, active-high reset
//   audio_in     NUM_CH*{L,R} signed samples; source k at
//                [(2k+2)*IN_W-1 : 2k*IN_W], L in the upper half
//   vol          per-source volume; source k at [(k+1)*VOL_W-1 : k*VOL_W]
//   mute         global mute request, applied at the next sample
//   clk_audio    square wave at SAMPLE_RATE
//   sample_word  {L,R} signed mixed output
//   sample_tick  one-cycle pulse when sample_word updates
//   clip         set for a whole sample period if the current word saturated
//
// Handshake: sample_tick is a valid strobe with no ready. sample_word and
// clip change only in the cycle sample_tick is high and hold until the
// next pulse, so the consumer may sample them at any time.
// ---------------------------------------------------------------------------
module audio_mixer_out #(
  parameter int CLK_HZ      = 32000000,
  parameter int SAMPLE_RATE = 48000,
  parameter int NUM_CH      = 2,
  parameter int IN_W        = 16,
  parameter int OUT_W       = 16,
  parameter int VOL_W       = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*2*IN_W-1:0] audio_in,
  input  logic [NUM_CH*VOL_W-1:0]  vol,
  input  logic                     mute,
  output logic                     clk_audio,
  output logic [2*OUT_W-1:0]       sample_word,
  output logic                     sample_tick,
  output logic                     clip
);

  localparam logic [31:0] STEP  = 32'(2 * SAMPLE_RATE);
  localparam logic [31:0] LIMIT = 32'(CLK_HZ);

  // Gain is one bit wider than vol so that full scale is exactly 2^VOL_W.
  localparam int GW     = VOL_W + 1;
  localparam int AW     = IN_W + VOL_W + $clog2(NUM_CH) + 2;
  // Signed sample times a zero-extended (hence non-negative) gain.
  localparam int PW     = IN_W + GW + 1;
  localparam int SHL    = (OUT_W >= IN_W) ? (OUT_W - IN_W) : 0;
  localparam int SHR    = (OUT_W <  IN_W) ? (IN_W - OUT_W) : 0;
  // Scaling width leaves room for the left alignment shift.
  localparam int SW     = AW + SHL;
  localparam int IDX_W  = $clog2(2 * NUM_CH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 * NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_SCALE,
    S_OUT
  } state_t;

  state_t                   state;
  logic [31:0]              div_acc;
  logic [31:0]              div_sum;
  logic                     div_tog;
  logic                     tick;
  logic [NUM_CH*2*IN_W-1:0] hold;
  logic [GW-1:0]            gain [NUM_CH];
  logic [IDX_W-1:0]         idx;
  logic signed [AW-1:0]     acc_l;
  logic signed [AW-1:0]     acc_r;
  logic [OUT_W-1:0]         res_l;
  logic [OUT_W-1:0]         res_r;
  logic                     sat_l;
  logic                     sat_r;
  logic [IN_W-1:0]          cur_sample;
  logic [GW-1:0]            cur_gain;
  logic signed [PW-1:0]     prod;

  // -------------------------------------------------------------------------
  // Fractional divider: one clk_audio toggle each time the running sum
  // crosses CLK_HZ, so half periods are floor or ceil of CLK_HZ/(2*rate).
  // -------------------------------------------------------------------------
  assign div_sum = div_acc + STEP;
  assign div_tog = (div_sum >= LIMIT);
  // Start a sample on the falling edge; the word is then stable long before
  // the next rising edge that the encoder uses.
  assign tick    = div_tog & clk_audio;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_acc   <= '0;
      clk_audio <= 1'b0;
    end else if (div_tog) begin
      div_acc   <= div_sum - LIMIT;
      clk_audio <= ~clk_audio;
    end else begin
      div_acc   <= div_sum;
    end
  end

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  function automatic logic [GW-1:0] target_of(input logic [VOL_W-1:0] v,
                                              input logic             m);
    if (m || (v == '0)) return '0;
    else if (&v)        return {1'b1, {VOL_W{1'b0}}};
    else                return GW'(v);
  endfunction

  // Returns {saturated, value}.
  function automatic logic [OUT_W:0] scale_sat(input logic signed [AW-1:0] a);
    logic signed [SW-1:0] t;
    logic                 in_range;
    t = SW'(a);
    t = t >>> VOL_W;
    t = t <<< SHL;
    t = t >>> SHR;
    // In range when every bit above the output sign bit copies the sign.
    in_range = (&t[SW-1:OUT_W-1]) || (~|t[SW-1:OUT_W-1]);
    if (in_range)     return {1'b0, t[OUT_W-1:0]};
    else if (t[SW-1]) return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    else              return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  // Operand select for the product of the current ACC step. Even steps are
  // left channels, odd steps right; L sits in the upper half of each source,
  // hence the bit flip on the slot number.
  always_comb begin
    cur_sample = '0;
    cur_gain   = '0;
    for (int k = 0; k < 2 * NUM_CH; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_sample = hold[(k ^ 1) * IN_W +: IN_W];
        cur_gain   = gain[k / 2];
      end
    end
    prod = PW'($signed(cur_sample)) * PW'($signed({1'b0, cur_gain}));
  end

  // -------------------------------------------------------------------------
  // Mixing FSM: IDLE -> ACC (2*NUM_CH cycles) -> SCALE -> OUT -> IDLE.
  // A tick seen outside IDLE is ignored and its sample dropped.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      hold        <= '0;
      idx         <= '0;
      acc_l       <= '0;
      acc_r       <= '0;
      res_l       <= '0;
      res_r       <= '0;
      sat_l       <= 1'b0;
      sat_r       <= 1'b0;
      sample_word <= '0;
      sample_tick <= 1'b0;
      clip        <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) gain[k] <= '0;
    end else begin
      sample_tick <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick) begin
            hold  <= audio_in;
            idx   <= '0;
            acc_l <= '0;
            acc_r <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
`ifdef AUDIO_VOL_RAMP_EN
              if (gain[k] < target_of(vol[k*VOL_W +: VOL_W], mute))
                gain[k] <= gain[k] + GW'(1);
              else if (gain[k] > target_of(vol[k*VOL_W +: VOL_W], mute))
                gain[k] <= gain[k] - GW'(1);
`else
              gain[k] <= target_of(vol[k*VOL_W +: VOL_W], mute);
`endif
            end
            state <= S_ACC;
          end
        end
        S_ACC: begin
          if (idx[0] == 1'b0) acc_l <= acc_l + AW'(prod);
          else                acc_r <= acc_r + AW'(prod);
          if (idx == IDX_LAST) state <= S_SCALE;
          else                 idx   <= idx + IDX_W'(1);
        end
        S_SCALE: begin
          {sat_l, res_l} <= scale_sat(acc_l);
          {sat_r, res_r} <= scale_sat(acc_r);
          state          <= S_OUT;
        end
        S_OUT: begin
          sample_word <= {res_l, res_r};
          clip        <= sat_l | sat_r;
          sample_tick <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_mixer_out.sv
// ---------------------------------------------------------------------------
// tb_audio_mixer_out
//
// Bench for audio_mixer_out. The sample rate is raised so that a half
// period is 32/3 clk cycles, which keeps every scenario short while keeping
// the divider fractional. A reference model derives the clk_audio level and
// every expected output word from the arithmetic rules; the monitor compares
// DUT outputs against the model's queue.
// ---------------------------------------------------------------------------
module tb_audio_mixer_out;

  localparam int CLK_HZ = 32000000;
  localparam int SR     = 1500000;
  localparam int NCH    = 2;
  localparam int IW     = 16;
  localparam int OW     = 16;
  localparam int VW     = 4;
  localparam int LAT    = 2 * NCH + 2;
  localparam int HP_LO  = CLK_HZ / (2 * SR);
  localparam int HP_HI  = HP_LO + 1;
  // Rising-edge window: 1600 cycles hold exactly 150 toggles for this ratio.
  localparam int WIN_LO = 100;
  localparam int WIN_HI = 1700;
`ifdef AUDIO_VOL_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  // ---- clock / reset -------------------------------------------------------
  logic                  clk = 1'b0;
  logic                  reset;
  logic [NCH*2*IW-1:0]   audio_in;
  logic [NCH*VW-1:0]     vol;
  logic                  mute;
  logic                  clk_audio;
  logic [2*OW-1:0]       sample_word;
  logic                  sample_tick;
  logic                  clip;

  always #5 clk = ~clk;

  audio_mixer_out #(
    .CLK_HZ(CLK_HZ), .SAMPLE_RATE(SR), .NUM_CH(NCH),
    .IN_W(IW), .OUT_W(OW), .VOL_W(VW)
  ) dut (
    .clk(clk), .reset(reset), .audio_in(audio_in), .vol(vol), .mute(mute),
    .clk_audio(clk_audio), .sample_word(sample_word),
    .sample_tick(sample_tick), .clip(clip)
  );

  // ---- scoreboard state ----------------------------------------------------
  // Entry: {cycle[31:0], clip, word[31:0]}
  logic [64:0] exp_q[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          n          = 0;   // clk edges since reset release
  int          tick_cnt   = 0;   // model sample starts
  int          g [NCH];          // model gains
  logic [31:0] last_word  = '0;
  logic        last_clip  = 1'b0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp_v);
    compared++;
    if (act !== exp_v) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, n);
    end
  endtask

  // Total clk_audio toggles after m edges: floor(m * 2*SR / CLK_HZ).
  function automatic longint tcount(input int m);
    return (longint'(m) * longint'(2 * SR)) / longint'(CLK_HZ);
  endfunction

  function automatic int sat16(input int v, output bit c);
    c = 1'b0;
    if (v > 32767)  begin c = 1'b1; return 32767;  end
    if (v < -32768) begin c = 1'b1; return -32768; end
    return v;
  endfunction

  // ---- reference model -----------------------------------------------------
  initial begin
    for (int k = 0; k < NCH; k++) g[k] = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        n = 0;
        for (int k = 0; k < NCH; k++) g[k] = 0;
        exp_q.delete();
      end else begin
        n++;
        // A sample starts when clk_audio falls: a new toggle bringing the
        // toggle count to an even number.
        if (tcount(n) != tcount(n - 1) && (tcount(n) % 2) == 0) begin
          int sum_l, sum_r, vl, vr, tgt, v;
          bit cl, cr;
          tick_cnt++;
          sum_l = 0;
          sum_r = 0;
          for (int k = 0; k < NCH; k++) begin
            v = int'(vol[k*VW +: VW]);
            if (mute || v == 0)        tgt = 0;
            else if (v == (1 << VW) - 1) tgt = 1 << VW;
            else                       tgt = v;
            if (RAMP) begin
              if (g[k] < tgt)      g[k] = g[k] + 1;
              else if (g[k] > tgt) g[k] = g[k] - 1;
            end else begin
              g[k] = tgt;
            end
            sum_l += int'($signed(audio_in[(2*k+1)*IW +: IW])) * g[k];
            sum_r += int'($signed(audio_in[(2*k)*IW +: IW])) * g[k];
          end
          vl = sat16(sum_l >>> VW, cl);
          vr = sat16(sum_r >>> VW, cr);
          exp_q.push_back({32'(n + LAT), (cl | cr), 16'(vl), 16'(vr)});
        end
      end
    end
  end

  // ---- monitor -------------------------------------------------------------
  initial begin
    logic [64:0] e;
    logic        prev_ca  = 1'b0;
    int          half_len = 0;
    bit          seen_tog = 1'b0;
    int          rise_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("reset_word", 64'(sample_word), 64'(0));
        check("reset_tick", 64'(sample_tick), 64'(0));
        check("reset_clk_audio", 64'(clk_audio), 64'(0));
        check("reset_clip", 64'(clip), 64'(0));
        prev_ca  = 1'b0;
        half_len = 0;
        seen_tog = 1'b0;
      end else begin
        check("clk_audio_level", 64'(clk_audio), 64'(tcount(n) % 2));
        if (clk_audio === prev_ca) begin
          half_len++;
        end else begin
          if (seen_tog)
            check("half_period", 64'(half_len == HP_LO || half_len == HP_HI), 64'(1));
          if (clk_audio === 1'b1 && n > WIN_LO && n <= WIN_HI) rise_cnt++;
          seen_tog = 1'b1;
          half_len = 1;
        end
        prev_ca = clk_audio;
        if (n == WIN_HI)
          check("rise_count", 64'(rise_cnt),
                64'((longint'(WIN_HI - WIN_LO) * 2 * SR / CLK_HZ) / 2));

        if (exp_q.size() > 0 && exp_q[0][64:33] == 32'(n)) begin
          e = exp_q.pop_front();
          check("sample_tick", 64'(sample_tick), 64'(1));
          check("sample_word", 64'(sample_word), 64'(e[31:0]));
          check("clip", 64'(clip), 64'(e[32]));
          last_word = sample_word;
          last_clip = clip;
        end else begin
          check("spurious_tick", 64'(sample_tick), 64'(0));
        end
      end
    end
  end

  // ---- driver tasks --------------------------------------------------------
  task automatic set_src(input int k, input logic [15:0] l, input logic [15:0] r);
    audio_in[(2*k+1)*IW +: IW] = l;
    audio_in[(2*k)*IW +: IW]   = r;
  endtask

  // Waits on the model's own sample count, so it always terminates.
  task automatic wait_ticks(input int k);
    int tgt;
    tgt = tick_cnt + k;
    while (tick_cnt < tgt) @(negedge clk);
  endtask

  // Lets the word of the most recent sample reach the output.
  task automatic settle();
    repeat (LAT + 1) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog");
  end

  // ---- stimulus ------------------------------------------------------------
  initial begin
    reset    = 1'b1;
    audio_in = '0;
    vol      = '0;
    mute     = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;

    // Ramp from reset at full volume.
    vol = '1;
    set_src(0, 16'h1000, 16'h0000);
    wait_ticks(1); settle();
    check("ramp_first", 64'(last_word), 64'(RAMP ? 32'h0100_0000 : 32'h1000_0000));
    wait_ticks(16); settle();
    check("ramp_settled", 64'(last_word), 64'(32'h1000_0000));

    // Saturation with both sources at full gain.
    set_src(0, 16'h7000, 16'h9000);
    set_src(1, 16'h7000, 16'h9000);
    wait_ticks(2); settle();
    check("sat_word", 64'(last_word), 64'(32'h7FFF_8000));
    check("sat_clip", 64'(last_clip), 64'(1));
    set_src(0, 16'h3000, 16'hD000);
    set_src(1, 16'h3000, 16'hD000);
    wait_ticks(2); settle();
    check("half_word", 64'(last_word), 64'(32'h6000_A000));
    check("half_clip", 64'(last_clip), 64'(0));

    // Volume step down to 8, then to 0.
    set_src(1, 16'h0000, 16'h0000);
    set_src(0, 16'h4000, 16'h0000);
    vol[VW-1:0] = 4'd8;
    wait_ticks(10); settle();
    check("vol8_settled", 64'(last_word), 64'(32'h2000_0000));
    vol[VW-1:0] = 4'd0;
    wait_ticks(1); settle();
    check("vol0_first", 64'(last_word), 64'(RAMP ? 32'h1C00_0000 : 32'h0000_0000));
    wait_ticks(8); settle();
    check("vol0_settled", 64'(last_word), 64'(0));

    // Mute and release.
    set_src(0, 16'h1000, 16'h0000);
    vol = '1;
    wait_ticks(17); settle();
    check("premute", 64'(last_word), 64'(32'h1000_0000));
    mute = 1'b1;
    wait_ticks(16); settle();
    check("muted", 64'(last_word), 64'(0));
    mute = 1'b0;
    wait_ticks(16); settle();
    check("unmuted", 64'(last_word), 64'(32'h1000_0000));

    // Random traffic.
    repeat (40) begin
      audio_in = {$urandom(), $urandom()};
      vol      = 8'($urandom());
      mute     = ($urandom_range(0, 7) == 0);
      wait_ticks($urandom_range(1, 3));
    end

    // Reset two cycles into a sample.
    audio_in = '0;
    vol      = '1;
    mute     = 1'b0;
    set_src(0, 16'h1000, 16'h0000);
    wait_ticks(1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_word", 64'(sample_word), 64'(0));
    check("midreset_clk_audio", 64'(clk_audio), 64'(0));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_ticks(1); settle();
    check("restart_first", 64'(last_word), 64'(RAMP ? 32'h0100_0000 : 32'h1000_0000));
    wait_ticks(1); settle();
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/audio_mixer_out.md
Name: audio_mixer_out

Overview:
- Parametrised HDMI audio back end: generates the audio sample clock from the pixel clock with an exact fractional divider.
- Mixes NUM_CH stereo sources with per-source ramped volume and a global mute, saturates, and presents a stable stereo word to the HDMI encoder.
- Sits between the core audio sources and the hdmi instance in the video top level.
- Replaces the integer clock divider and the fixed 4-step volume shifts.

Parameters:
- CLK_HZ, 32000000, input clock frequency in Hz.
- SAMPLE_RATE, 48000, output sample rate in Hz. Requires CLK_HZ/(2*SAMPLE_RATE) > NUM_CH*2+4.
- NUM_CH, 2, number of stereo input sources, 1..8.
- IN_W, 16, signed input sample width.
- OUT_W, 16, signed output sample width.
- VOL_W, 4, volume control width per source.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- audio_in  in  NUM_CH*2*IN_W  packed signed samples; source k occupies bits [(2k+2)*IN_W-1 : 2k*IN_W] as {L,R}, L upper.
- vol  in  NUM_CH*VOL_W  per-source volume, source k at [(k+1)*VOL_W-1 : k*VOL_W].
- mute  in  1  global mute request.
- clk_audio  out  1  square wave at SAMPLE_RATE.
- sample_word  out  2*OUT_W  {L,R} signed mixed output.
- sample_tick  out  1  one-cycle pulse when sample_word updates.
- clip  out  1  high for a whole sample period if L or R of the current sample_word saturated.

Behaviour:
- Reset values: clk_audio=0, sample_word=0, sample_tick=0, clip=0, accumulator=0, all gains=0, FSM=IDLE.
- Reset is honoured in any state; an in-flight sample is discarded and no sample_tick is issued for it.
- Divider (Bresenham):
  - acc (32 bits) += 2*SAMPLE_RATE every clk.
  - When acc+2*SAMPLE_RATE >= CLK_HZ: acc <= acc+2*SAMPLE_RATE-CLK_HZ and clk_audio toggles.
  - The long-run rate is exact; half periods are floor or ceil of CLK_HZ/(2*SAMPLE_RATE).
- tick: internal one-cycle strobe, the cycle clk_audio toggles 1->0. The new word is therefore stable well before the next rising edge.
- On tick (IDLE only):
  - snapshot audio_in into a holding register;
  - compute target_k = 0 if mute or vol_k==0; 2^VOL_W if vol_k is all ones; otherwise vol_k;
  - gain_k (VOL_W+1 bits) steps by exactly 1 toward target_k; the new gain is used for this sample;
  - enter ACC.
- ACC: one product per cycle, order src0 L, src0 R, src1 L, ... (2*NUM_CH cycles).
  - Each product is sample(signed) * gain(unsigned) into a signed accumulator, one for L and one for R.
  - Accumulator width = IN_W+VOL_W+clog2(NUM_CH)+2; no internal overflow is possible.
- SCALE (1 cycle):
  - arithmetic shift right by VOL_W;
  - align to OUT_W: shift left by OUT_W-IN_W if OUT_W>=IN_W, else arithmetic shift right (truncate);
  - saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- OUT (1 cycle): register sample_word, pulse sample_tick, set clip from saturation of either channel; return to IDLE.
- Latency: sample_tick fires 2*NUM_CH+2 cycles after tick.
- A tick arriving outside IDLE is ignored; that sample is dropped and gains do not step. The parameter constraint makes this unreachable.
- vol and mute changes take effect at the next tick only.

Optional Feature:
- Macro: AUDIO_VOL_RAMP_EN.
- Defined: gains ramp 1 step per sample, as described above; this is pop-free on reset, mute and volume changes.
- Undefined: gain_k <= target_k directly at each tick; gain at reset is still 0, so the first sample after reset already uses the full target.

Test Plan:
- Defaults, count clk_audio rising edges over 32,000,000 clk cycles -> exactly 48000; every half period is 333 or 334 cycles.
- Ramp from reset: vol=all ones, src0 L=0x1000, all other inputs 0 -> first sample_word L=0x0100, R=0x0000; +0x0100 per sample; L=0x1000 from the 16th sample on; sample_tick 6 cycles after each falling clk_audio.
- Saturation: both sources L=0x7000, R=-0x7000 at full gain, settled -> L=0x7FFF, R=0x8000, clip=1; inputs halved to 0x3000 -> L=0x6000, clip=0.
- Volume step: vol0=8, src0 L=0x4000 -> settles to 0x2000; then vol0=0 -> L falls 0x0400 per sample, reaching 0 after 8 samples (without AUDIO_VOL_RAMP_EN: 0 on the next sample).
- Mute: settled L=0x1000 at full gain, assert mute -> ramps to 0 in 16 samples; release -> back to 0x1000 after 16 samples.
- Reset mid-operation: assert reset 2 cycles after tick -> sample_word=0 and clk_audio=0 immediately, no sample_tick for that sample; after release the gain ramp restarts from 0.
